// File: rtl/chip8_pkg.sv
// Shared CHIP-8 timer types and the common DT/ST next-value rule.
// Pure declarations; no latency, no backpressure.
package chip8_pkg;

    localparam int TIMER_W = 8;
    localparam int TONE_W  = 16;

    typedef logic [TIMER_W-1:0] timer_t;

    // A write beats the tick; a tick at zero saturates instead of wrapping.
    function automatic timer_t timer_next(
        input timer_t cur,
        input logic   we,
        input timer_t wval,
        input logic   tick
    );
        timer_t nxt;
        nxt = cur;
        if (we) begin
            nxt = wval;
        end else if (tick && (cur != '0)) begin
            nxt = cur - TIMER_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/chip8_tone_div.sv
// Speaker square-wave divider: tone toggles every TONE_DIV clocks while en is high.
// Latency: starts low for a full half-period after en rises; no backpressure.
module chip8_tone_div
    import chip8_pkg::*;
#(
    parameter logic [TONE_W-1:0] TONE_DIV = 16'd6000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tone
);

    logic [TONE_W-1:0] cnt;

    // Holding everything at zero while disabled makes every burst start identically.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (cnt == (TONE_DIV - 16'd1)) begin
            cnt  <= '0;
            tone <= ~tone;
        end else begin
            cnt  <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/chip8_timers.sv
// CHIP-8 delay/sound timers ticked by vsync rising edges; beep and speaker drive.
// Writes visible one clk later; no backpressure. CHIP8_TONE_GEN_EN selects the tone divider.
module chip8_timers
    import chip8_pkg::*;
#(
    parameter logic [TONE_W-1:0] TONE_DIV = 16'd6000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               dt_we,
    input  logic               st_we,
    input  logic [TIMER_W-1:0] wdata,
    output logic [TIMER_W-1:0] dt_value,
    output logic [TIMER_W-1:0] st_value,
    output logic               tick,
    output logic               beep,
    output logic               spkr
);

    if (TONE_DIV < 16'd2) begin : g_bad_tone_div
        $error("chip8_timers: TONE_DIV must be at least 2");
    end

    logic vsync_q;

    // Combinational so a tick lands in the same cycle vsync is first seen high.
    assign tick = vsync & ~vsync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q  <= 1'b0;
            dt_value <= '0;
            st_value <= '0;
        end else begin
            vsync_q  <= vsync;
            dt_value <= timer_next(dt_value, dt_we, wdata, tick);
            st_value <= timer_next(st_value, st_we, wdata, tick);
        end
    end

    assign beep = (st_value != '0);

`ifdef CHIP8_TONE_GEN_EN
    logic tone;

    chip8_tone_div #(
        .TONE_DIV (TONE_DIV)
    ) u_tone_div (
        .clk   (clk),
        .reset (reset),
        .en    (beep),
        .tone  (tone)
    );

    assign spkr = tone & beep;
`else
    // Frame-rate buzz: the speaker simply follows vsync while sounding.
    assign spkr = vsync & beep;
`endif

endmodule

// File: doc/chip8_timers.md
# chip8_timers

CHIP-8 delay/sound timer unit with speaker drive, sitting between the CPU core and the top-level `spkr` pin. Generates the 60 Hz timer tick from `vsync` rising edges and holds the architectural DT and ST registers, loaded by the CPU (`LD DT,Vx` / `LD ST,Vx`) and read back for `LD Vx,DT`. Produces `beep` while ST is non-zero and, optionally, an audible square wave on `spkr`.

## Interface
Parameters:
- `TONE_DIV`, 16'd6000, clk cycles per half-period of the speaker tone; legal range 2..65535.

Ports:
- `clk`  in  1  system clock, same domain as the hvsync generator
- `reset`  in  1  asynchronous, active-low reset
- `vsync`  in  1  vertical sync from the hvsync generator, active-high
- `dt_we`  in  1  load DT from `wdata` this cycle
- `st_we`  in  1  load ST from `wdata` this cycle
- `wdata`  in  8  value to load
- `dt_value`  out  8  current DT
- `st_value`  out  8  current ST
- `tick`  out  1  one-cycle 60 Hz tick pulse
- `beep`  out  1  high while ST != 0
- `spkr`  out  1  speaker drive

## Operation
- Edge detect: `vsync_q` registers `vsync` every cycle; `tick = vsync & ~vsync_q`, combinational.
- DT update, priority order: `dt_we` → load `wdata`; else `tick` and DT != 0 → DT-1; else hold. ST identical with `st_we`.
- Write and tick in the same cycle: write wins, no decrement that cycle.
- `dt_we` and `st_we` together: both load the same `wdata`.
- Saturation: at 0 a tick leaves the counter at 0; no wrap to 8'hFF.
- Loading 0 stops the counter immediately; loading 8'hFF gives 255 ticks to zero.
- `beep = (st_value != 0)`, combinational from the register.
- `tick` rate follows `vsync` exactly; no pulse is generated while `vsync` is held high or low.

## Timing
- Reset (async, `reset` low): DT=0, ST=0, `vsync_q`=0, tone counter=0, tone bit=0. All outputs 0, except `tick`, which follows `vsync` (a reset release with `vsync` high gives a tick on the first clock).
- Write latency: `dt_value`/`st_value` show the new value one clk after the edge that samples `*_we`.
- Tick latency: `vsync` first sampled high at edge N makes `tick` high during the cycle before edge N. The decrement is visible after edge N.
- `beep` falls in the same cycle ST reaches 0. `beep` rises one cycle after an ST load of a non-zero value.
- Reset asserted mid-count aborts the count. Timers do not resume after release.

## Configuration
- `CHIP8_TONE_GEN_EN` defined: 16-bit counter runs only while `beep` is high.
  - Counts 0..`TONE_DIV`-1; at the wrap the tone bit toggles.
  - `spkr = tone & beep`.
  - When `beep` is low, the counter and tone bit are held at 0, so every beep starts with a low half-period of exactly `TONE_DIV` cycles.
- Undefined: no tone counter; `spkr = vsync & beep`, which is the frame-rate buzz of the existing top level.

## Structure
- Shared package `chip8_pkg`:
  - `TIMER_W` = 8
  - `TONE_W` = 16
  - typedef `timer_t` (logic [7:0]), reused by the CPU for Vx↔timer transfers.
- One sub-module, `chip8_tone_div`, containing the tone counter and toggle. It is instantiated only under `CHIP8_TONE_GEN_EN`.
- Edge detect and the two timer registers stay in `chip8_timers`.

## Test plan
- Reset, then drive a `vsync` period of 100 clks. Pulse `dt_we` with `wdata`=3. Expect `dt_value` 3→2→1→0 on three successive `vsync` rising edges, then held at 0 through 5 further ticks.
- Assert `st_we` with `wdata`=5 in the exact cycle `tick`=1. Expect `st_value`=5 after the edge (no decrement), then 4 after the next tick.
- Load ST=2. Expect `beep`=1 for exactly two tick intervals, and `beep`=0 in the cycle ST becomes 0.
- With `CHIP8_TONE_GEN_EN` and `TONE_DIV`=4, load ST=1. Expect `spkr` low 4 clks, high 4 clks, repeating until the tick, then 0; counter back at 0.
- Without the macro, ST=1. Expect `spkr` to equal `vsync` while `beep`=1, and 0 otherwise.
- Load DT=10 and ST=10, then pulse `reset` low mid-count for one partial cycle. Expect DT=ST=0, `beep`=0 and `spkr`=0 immediately (asynchronously), and no decrements after release.
